// File: rtl/perf_monitor.sv
// perf_monitor -- pipeline performance-monitor unit for the RV32I core.
//
// Samples per-cycle event strobes and keeps five counters: cycle, retired
// instructions, stall cycles, resolved branches and mispredicted branches.
// Offers a registered read port and sticky per-counter overflow flags.
// Counting freezes on the end-of-program marker (halt) until clear.
//
// Optional build macro:
//   PERF_SAT_EN  counters saturate at all-ones instead of wrapping to 0.
//
// Ports:
//   clk, reset            core clock; asynchronous active-low reset
//   retire_valid          one instruction retired this cycle
//   pipe_stall            hazard-unit stall this cycle
//   icache_stall          I-cache miss stall this cycle
//   branch_resolved       a branch or jump resolved this cycle
//   branch_mispredict     resolved branch was mispredicted (needs branch_resolved)
//   halt                  end marker; freezes all counters and flags
//   clear                 synchronous clear of counters, flags and freeze
//   rd_req, rd_sel        read request and register select
//   cycle_count .. branch_mispredicts   live counter values
//   overflow              sticky flags {mispredict, branch, stall, instr, cycle}
//   frozen                high while counting is frozen
//   rd_valid, rd_data     registered read response, one cycle after rd_req

module perf_monitor #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 retire_valid,
  input  logic                 pipe_stall,
  input  logic                 icache_stall,
  input  logic                 branch_resolved,
  input  logic                 branch_mispredict,
  input  logic                 halt,
  input  logic                 clear,
  input  logic                 rd_req,
  input  logic [2:0]           rd_sel,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instruction_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] branch_mispredicts,
  output logic [4:0]           overflow,
  output logic                 frozen,
  output logic                 rd_valid,
  output logic [CNT_WIDTH-1:0] rd_data
);

  // state  | meaning
  // RUN    | counters advance on their event strobes
  // FROZEN | halt seen; counters and overflow flags hold until clear
  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Counter index order matches the overflow bit order.
  logic [CNT_WIDTH-1:0] cnt     [5];
  logic [CNT_WIDTH-1:0] cnt_nxt [5];
  logic [4:0]           ovf_nxt;
  logic [4:0]           ev;
  logic [CNT_WIDTH-1:0] rd_mux;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // clear wins over halt, so a clear+halt cycle lands in RUN.
  always_comb begin
    state_nxt = state;
    if (clear)                      state_nxt = RUN;
    else if (state == RUN && halt)  state_nxt = FROZEN;
  end

  assign frozen = (state == FROZEN);

  // Halt-cycle events still count: gating uses the current state, not halt.
  always_comb begin
    ev = {branch_resolved & branch_mispredict,
          branch_resolved,
          pipe_stall | icache_stall,
          retire_valid,
          1'b1};
    ovf_nxt = overflow;
    for (int i = 0; i < 5; i++) begin
      cnt_nxt[i] = cnt[i];
      if (clear) begin
        cnt_nxt[i] = '0;
      end else if (state == RUN && ev[i]) begin
        if (&cnt[i]) begin
          ovf_nxt[i] = 1'b1;
`ifdef PERF_SAT_EN
          cnt_nxt[i] = cnt[i];
`else
          cnt_nxt[i] = '0;
`endif
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
    if (clear) ovf_nxt = '0;
  end

  // Read mux works on pre-edge register values, so a same-cycle clear or
  // increment never leaks into the returned data.
  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      3'd0:    rd_mux = cnt[0];
      3'd1:    rd_mux = cnt[1];
      3'd2:    rd_mux = cnt[2];
      3'd3:    rd_mux = cnt[3];
      3'd4:    rd_mux = cnt[4];
      3'd5:    rd_mux = CNT_WIDTH'({frozen, overflow});
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
      overflow <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      for (int i = 0; i < 5; i++) cnt[i] <= cnt_nxt[i];
      overflow <= ovf_nxt;
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
    end
  end

  assign cycle_count        = cnt[0];
  assign instruction_count  = cnt[1];
  assign stall_count        = cnt[2];
  assign branch_count       = cnt[3];
  assign branch_mispredicts = cnt[4];

endmodule

// File: tb/tb_perf_monitor.sv
module tb_perf_monitor;

`ifdef PERF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic retire_valid = 0, pipe_stall = 0, icache_stall = 0;
  logic branch_resolved = 0, branch_mispredict = 0;
  logic halt = 0, clear = 0, rd_req = 0;
  logic [2:0] rd_sel = 3'd0;

  logic [31:0] a_cyc, a_ins, a_stl, a_br, a_mp, a_rdd;
  logic [4:0]  a_ovf;
  logic        a_frz, a_rdv;
  logic [3:0]  b_cyc, b_ins, b_stl, b_br, b_mp, b_rdd;
  logic [4:0]  b_ovf;
  logic        b_frz, b_rdv;

  always #5 clk = ~clk;

  perf_monitor #(.CNT_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset),
    .retire_valid(retire_valid), .pipe_stall(pipe_stall), .icache_stall(icache_stall),
    .branch_resolved(branch_resolved), .branch_mispredict(branch_mispredict),
    .halt(halt), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
    .cycle_count(a_cyc), .instruction_count(a_ins), .stall_count(a_stl),
    .branch_count(a_br), .branch_mispredicts(a_mp),
    .overflow(a_ovf), .frozen(a_frz), .rd_valid(a_rdv), .rd_data(a_rdd));

  perf_monitor #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .retire_valid(retire_valid), .pipe_stall(pipe_stall), .icache_stall(icache_stall),
    .branch_resolved(branch_resolved), .branch_mispredict(branch_mispredict),
    .halt(halt), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
    .cycle_count(b_cyc), .instruction_count(b_ins), .stall_count(b_stl),
    .branch_count(b_br), .branch_mispredicts(b_mp),
    .overflow(b_ovf), .frozen(b_frz), .rd_valid(b_rdv), .rd_data(b_rdd));

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, one per instance (0: 32-bit, 1: 4-bit).
  longint unsigned m_cnt [2][5];
  logic [4:0]      m_ovf [2];
  bit              m_frz [2];
  bit              m_rdv [2];
  longint unsigned m_rdd [2];

  function automatic longint unsigned cmax(int k);
    return (k == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  task automatic model_zero();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) m_cnt[k][i] = 0;
      m_ovf[k] = '0; m_frz[k] = 0; m_rdv[k] = 0; m_rdd[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    longint unsigned rv;
    bit ev [5];
    rv = 0;
    if (rd_sel < 3'd5)       rv = m_cnt[k][rd_sel];
    else if (rd_sel == 3'd5) rv = longint'({m_frz[k], m_ovf[k]}) & cmax(k);
    m_rdv[k] = rd_req;
    if (rd_req) m_rdd[k] = rv;
    ev[0] = 1;
    ev[1] = retire_valid;
    ev[2] = pipe_stall || icache_stall;
    ev[3] = branch_resolved;
    ev[4] = branch_resolved && branch_mispredict;
    if (clear) begin
      for (int i = 0; i < 5; i++) m_cnt[k][i] = 0;
      m_ovf[k] = '0;
      m_frz[k] = 0;
    end else if (!m_frz[k]) begin
      for (int i = 0; i < 5; i++) if (ev[i]) begin
        if (m_cnt[k][i] == cmax(k)) begin
          m_ovf[k][i] = 1'b1;
          m_cnt[k][i] = SAT ? cmax(k) : 0;
        end else begin
          m_cnt[k][i] = m_cnt[k][i] + 1;
        end
      end
      if (halt) m_frz[k] = 1;
    end
  endtask

  task automatic compare_all();
    longint unsigned a [5];
    longint unsigned b [5];
    a[0] = a_cyc; a[1] = a_ins; a[2] = a_stl; a[3] = a_br; a[4] = a_mp;
    b[0] = b_cyc; b[1] = b_ins; b[2] = b_stl; b[3] = b_br; b[4] = b_mp;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("w32 cnt%0d", i), a[i], m_cnt[0][i]);
      chk($sformatf("w4 cnt%0d", i), b[i], m_cnt[1][i]);
    end
    chk("w32 overflow", a_ovf, m_ovf[0]);
    chk("w4 overflow",  b_ovf, m_ovf[1]);
    chk("w32 frozen", a_frz, m_frz[0]);
    chk("w4 frozen",  b_frz, m_frz[1]);
    chk("w32 rd_valid", a_rdv, m_rdv[0]);
    chk("w4 rd_valid",  b_rdv, m_rdv[1]);
    if (m_rdv[0]) chk("w32 rd_data", a_rdd, m_rdd[0]);
    if (m_rdv[1]) chk("w4 rd_data",  b_rdd, m_rdd[1]);
  endtask

  initial model_zero();

  always @(negedge reset) model_zero();

  always @(posedge clk) begin
    if (!reset) model_zero();
    else for (int k = 0; k < 2; k++) model_step(k);
    #1;
    compare_all();
  end

  task automatic idle();
    retire_valid = 0; pipe_stall = 0; icache_stall = 0;
    branch_resolved = 0; branch_mispredict = 0;
    halt = 0; clear = 0; rd_req = 0; rd_sel = 3'd0;
  endtask

  task automatic rand_events();
    retire_valid      = 1'($urandom_range(0, 1));
    pipe_stall        = 1'($urandom_range(0, 1));
    icache_stall      = 1'($urandom_range(0, 1));
    branch_resolved   = 1'($urandom_range(0, 1));
    branch_mispredict = 1'($urandom_range(0, 1));
  endtask

  // {retire, pipe_stall, icache_stall, branch_resolved, branch_mispredict}
  logic [4:0] mix [8] = '{5'b11100, 5'b11111, 5'b11110, 5'b10100,
                          5'b10001, 5'b00000, 5'b00000, 5'b00000};

  int rdv_seen;

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset cycle", a_cyc, 0);
    chk("reset rd_valid", a_rdv, 0);
    chk("reset rd_data", a_rdd, 0);
    chk("reset frozen", a_frz, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle cycle=10", a_cyc, 10);
    chk("idle instr=0", a_ins, 0);
    chk("idle w4 cycle=10", b_cyc, 10);

    // event mix
    clear = 1;
    @(negedge clk);
    clear = 0;
    for (int i = 0; i < 8; i++) begin
      {retire_valid, pipe_stall, icache_stall, branch_resolved, branch_mispredict} = mix[i];
      @(negedge clk);
    end
    idle();
    chk("mix cycle", a_cyc, 8);
    chk("mix instr", a_ins, 5);
    chk("mix stall", a_stl, 4);
    chk("mix branch", a_br, 2);
    chk("mix mispredict", a_mp, 1);

    // halt with retire, hold, then clear+halt
    halt = 1; retire_valid = 1;
    @(negedge clk);
    idle();
    chk("halt instr", a_ins, 6);
    chk("halt frozen", a_frz, 1);
    repeat (20) begin
      rand_events();
      @(negedge clk);
    end
    idle();
    chk("frozen cycle", a_cyc, 9);
    chk("frozen instr", a_ins, 6);
    chk("frozen stall", a_stl, 4);
    chk("frozen still", a_frz, 1);
    clear = 1; halt = 1;
    @(negedge clk);
    idle();
    chk("clr cycle", a_cyc, 0);
    chk("clr instr", a_ins, 0);
    chk("clr frozen", a_frz, 0);
    @(negedge clk);
    chk("resume cycle", a_cyc, 1);

    // back-to-back reads
    rdv_seen = 0;
    for (int s = 0; s <= 7; s++) begin
      if (s > 0 && a_rdv) rdv_seen++;
      if (s == 7) chk("rd sel6 zero", a_rdd, 0);
      rand_events();
      rd_req = (s < 7);
      rd_sel = 3'(s);
      @(negedge clk);
    end
    chk("rd_valid after stream", a_rdv, 0);
    chk("rd_valid run length", rdv_seen, 7);
    idle();

    // overflow on the 4-bit instance
    clear = 1;
    @(negedge clk);
    clear = 0;
    repeat (17) @(negedge clk);
    chk("ovf w4 cycle", b_cyc, SAT ? 15 : 1);
    chk("ovf w4 flag0", b_ovf[0], 1);
    chk("ovf w32 cycle", a_cyc, 17);
    chk("ovf w32 flag0", a_ovf[0], 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_events();
      halt   = ($urandom_range(0, 49) == 0);
      clear  = ($urandom_range(0, 39) == 0);
      rd_req = 1'($urandom_range(0, 1));
      rd_sel = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    idle();

    // async reset while frozen with a read in flight
    halt = 1;
    @(negedge clk);
    halt = 0; rd_req = 1; rd_sel = 3'd0;
    @(posedge clk);
    #3;
    chk("pre-reset frozen", a_frz, 1);
    chk("pre-reset rd_valid", a_rdv, 1);
    reset = 1'b0;
    #1;
    chk("async rd_valid", a_rdv, 0);
    chk("async rd_data", a_rdd, 0);
    chk("async frozen", a_frz, 0);
    chk("async cycle", a_cyc, 0);
    chk("async overflow", a_ovf, 0);
    chk("async w4 frozen", b_frz, 0);
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("post-reset cycle", a_cyc, 1);
    chk("post-reset frozen", a_frz, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Pipeline performance-monitor unit for the RV32I core. It sits downstream of the pipeline control logic and samples per-cycle event strobes: retire, pipeline stall, I-cache stall, branch resolve and branch mispredict. It maintains the cycle, instruction, stall, branch and mispredict counters that `top` exports. It also provides a registered read port and sticky overflow flags, and freezes all counters when the end-of-program marker is reached.

## Interface
- `CNT_WIDTH`, 32: width of every counter and of `rd_data`.
- `clk`  input  1  core clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low (asserted at 0); one clock domain.
- `retire_valid`  input  1  one instruction retired this cycle.
- `pipe_stall`  input  1  hazard-unit stall this cycle.
- `icache_stall`  input  1  I-cache miss stall this cycle.
- `branch_resolved`  input  1  a branch or jump resolved this cycle.
- `branch_mispredict`  input  1  the resolved branch was mispredicted; qualified by `branch_resolved`.
- `halt`  input  1  end marker detected; freezes counters.
- `clear`  input  1  synchronous clear of counters, flags and freeze.
- `rd_req`  input  1  read request.
- `rd_sel`  input  3  register select for the read.
- `cycle_count`, `instruction_count`, `stall_count`, `branch_count`, `branch_mispredicts`  output  CNT_WIDTH each  live counter values.
- `overflow`  output  5  sticky flags, ordered {mispredict, branch, stall, instr, cycle}, with cycle at bit 0.
- `frozen`  output  1  high while in the FROZEN state.
- `rd_valid`  output  1  read data valid.
- `rd_data`  output  CNT_WIDTH  read data.

## Operation
- The unit has two states, RUN and FROZEN. Reset enters RUN.
  - RUN→FROZEN on `halt`.
  - FROZEN→RUN only on `clear`.
- Increment rules, evaluated in RUN only, with each counter advancing by at most 1 per cycle:
  - cycle: +1 every cycle.
  - instruction: +1 when `retire_valid`.
  - stall: +1 when `pipe_stall | icache_stall`. A cycle with both asserted counts once.
  - branch: +1 when `branch_resolved`.
  - mispredict: +1 when `branch_resolved & branch_mispredict`. A mispredict strobe without `branch_resolved` is ignored.
- Halt cycle: events present in the same cycle as `halt` are counted. The counters then hold from the next edge onward.
- FROZEN: every counter and every `overflow` bit holds its value. Event inputs are ignored.
- `clear`:
  - On that edge, all counters go to 0, `overflow` goes to 0 and the state goes to RUN.
  - `clear` takes priority over increments and over `halt` in the same cycle.
  - The clear cycle itself is not counted.
- Wrap (default build): a counter at all-ones that increments goes to 0 and sets its `overflow` bit. The bit stays set until `clear` or reset.
- Read port:
  - `rd_req` sampled at edge N gives `rd_valid`=1 for exactly one cycle after that edge.
  - `rd_data` holds the value of the selected counter as it was before edge N's update.
  - `rd_sel` mapping:
    - 0 = cycle, 1 = instr, 2 = stall, 3 = branch, 4 = mispredict.
    - 5 = {`frozen`, `overflow`} zero-extended.
    - 6 and 7 read as 0.
  - Back-to-back requests are accepted every cycle.
  - Reads have no side effects and are serviced in both states.
  - A `clear` in the same cycle as a read does not affect the returned data.

## Timing
- Reset values: all counters 0, `overflow`=0, `frozen`=0, `rd_valid`=0, `rd_data`=0. State is RUN.
- Reset assertion takes effect asynchronously. Deassertion is released synchronously to `clk` by the upstream reset tree.
- Counter outputs are registered. An event at edge N is visible on the outputs after edge N.
- Read latency is 1 cycle.
- `frozen` rises the cycle after the `halt` edge.
- Reset asserted mid-read: `rd_valid` drops immediately and no data is returned.

## Configuration
- `PERF_SAT_EN` defined: counters saturate at all-ones instead of wrapping.
  - The `overflow` bit is set on the first attempted increment past all-ones.
  - The counter stays at all-ones until `clear`.
- `PERF_SAT_EN` undefined: wrap behaviour as described under Operation.

## Test plan
- Reset check:
  - Stimulus: hold `reset`=0 for 2 cycles, release, then run 10 idle cycles.
  - Required response: all outputs 0 during reset, then `cycle_count`=10 and all other counters 0.
- Event mix:
  - Stimulus: over 8 RUN cycles, 5 retires, 3 cycles with both stall inputs high and 1 with `icache_stall` only, 2 resolved branches with 1 mispredict, plus 1 extra mispredict strobe without `branch_resolved`.
  - Required response: instr=5, stall=4, branch=2, mispredicts=1.
- Halt and clear:
  - Stimulus: pulse `halt` together with `retire_valid`, run 20 more cycles, then pulse `clear` and `halt` in the same cycle.
  - Required response: instr includes the halt-cycle retire. All counters hold for the 20 cycles and `frozen`=1. After the clear+halt cycle, all counters are 0, `frozen`=0 and counting resumes.
- Read port:
  - Stimulus: `rd_req` with `rd_sel` 0,1,2,3,4,5,6 on consecutive cycles while events run.
  - Required response: `rd_valid` is high for 7 consecutive cycles. Each `rd_data` equals the selected counter's pre-edge value. Sel 6 returns 0.
- Overflow:
  - Stimulus: with `CNT_WIDTH`=4, run 17 cycles.
  - Required response: default build gives `cycle_count`=1 and `overflow[0]`=1. With `PERF_SAT_EN` defined, `cycle_count`=15 and `overflow[0]`=1.
- Async reset mid-operation:
  - Stimulus: assert `reset` between clock edges while in FROZEN with a read pending.
  - Required response: all outputs clear immediately and the state returns to RUN.
